// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit: sequences fetch/decode/execute/memory/writeback,
// drives datapath enables and mux selects, and decodes the ALU operation.
module multicycle_controller #(
  parameter int MEM_LAT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [3:0] LAT     = 4'(MEM_LAT);

  state_t     state_q, state_d;
  logic [3:0] wait_q,  wait_d;
  logic       pc_write_s, mem_write_s, ir_write_s, reg_write_s;

  // ALU operation from funct3; subtract only for R-type with funct7b5 set.
  function automatic logic [2:0] alu_decode(input logic is_r, input logic [2:0] f3,
                                            input logic f7b5);
    logic [2:0] ctl;
    case (f3)
      3'b000:  ctl = (is_r && f7b5) ? 3'b001 : 3'b000;
      3'b001:  ctl = 3'b100;
      3'b010:  ctl = 3'b101;
      3'b101:  ctl = 3'b110;
      3'b110:  ctl = 3'b011;
      3'b111:  ctl = 3'b010;
      default: ctl = 3'b000;
    endcase
    return ctl;
  endfunction

  // State and memory-wait counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state logic and per-state datapath controls.
  always_comb begin
    state_d     = S_FETCH;
    wait_d      = 4'd0;
    pc_write_s  = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s  = 1'b0;
    reg_write_s = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALUControl  = 3'b000;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (wait_q == LAT) begin
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
          state_d    = S_DECODE;
        end else begin
          wait_d  = wait_q + 4'd1;
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (wait_q == LAT) begin
          state_d = S_MEMWB;
        end else begin
          wait_d  = wait_q + 4'd1;
          state_d = S_MEMREAD;
        end
      end
      S_MEMWB: begin
        ResultSrc   = 2'b01;
        reg_write_s = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_decode(1'b1, funct3, funct7b5);
        state_d    = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_decode(1'b0, funct3, funct7b5);
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
      end
      S_JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        pc_write_s = 1'b1;
        state_d    = S_ALUWB;
      end
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        ALUControl = 3'b001;
        pc_write_s = Zero;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Immediate format selected straight from the opcode.
  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Write enables are suppressed for the whole reset cycle.
  assign PCWrite   = pc_write_s  & ~reset;
  assign MemWrite  = mem_write_s & ~reset;
  assign IRWrite   = ir_write_s  & ~reset;
  assign RegWrite  = reg_write_s & ~reset;
  assign state_dbg = state_q;

endmodule
